// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - tile-product control sequencer with instruction memory
//
// Purpose:
//   Holds a small instruction memory loaded by the host. On start it walks the
//   entries in order. Each nonzero entry K describes one 4x4 tile product with
//   inner dimension K. For each tile it streams operand column reads, waits one
//   cycle for the array output register, writes the 16 results back, and then
//   clears the accumulators. It raises ap_done when it finishes.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   addrI/dataI/enI  instruction write port, accepted only in IDLE/DONE
//   ap_start         start request, accepted only in IDLE/DONE
//   ap_done          level, high while in DONE
//   currInstruction  K of the tile in progress, 0 when not running
//   busy             high in every state except IDLE/DONE
//   rd_en/rd_col     operand column read strobe and column address
//   arr_clr          one-cycle accumulator clear after each tile
//   res_wr/res_addr/res_sel  result write strobe, output address, PE select
//   err              column-space overflow, sticky until the next accepted start
module inst_sequencer #(
    parameter int NUM_INST = 8,
    parameter int INST_W   = 5,
    parameter int COL_W    = 8,
    parameter int SKEW     = 6,
    parameter int TILE_N   = 16,
    parameter int RES_AW   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NUM_INST)-1:0] addrI,
    input  logic [INST_W-1:0]           dataI,
    input  logic                        enI,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic [INST_W-1:0]           currInstruction,
    output logic                        busy,
    output logic                        rd_en,
    output logic [COL_W-1:0]            rd_col,
    output logic                        arr_clr,
    output logic                        res_wr,
    output logic [RES_AW-1:0]           res_addr,
    output logic [3:0]                  res_sel,
    output logic                        err
);

    localparam int AW    = $clog2(NUM_INST);
    localparam int IDX_W = AW + 1;   // idx must be able to reach NUM_INST
    localparam int CW    = COL_W + 1; // column arithmetic needs one guard bit

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_WAIT,
        S_WB,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [INST_W-1:0] inst_q [NUM_INST];
    logic [INST_W-1:0] inst_d [NUM_INST];
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [INST_W-1:0] cur_k_q, cur_k_d;
    logic              err_q, err_d;

    logic [INST_W-1:0] fetch_k;
    logic [CW-1:0]     fetch_len;
    logic              fetch_end;
    logic              fetch_ovf;

    // Every tile after the first carries one pad column between streams.
    assign fetch_end = (idx_q == IDX_W'(NUM_INST)) || (fetch_k == '0);
    assign fetch_k   = inst_q[idx_q[AW-1:0]];
    assign fetch_len = CW'(fetch_k) + CW'(SKEW) + CW'(idx_q != '0);
    assign fetch_ovf = (col_q + fetch_len) > CW'(1 << COL_W);

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cur_k_d = cur_k_q;
        err_d   = err_q;

        rd_en    = 1'b0;
        rd_col   = '0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_sel  = '0;
        arr_clr  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (enI) begin
                    inst_d[addrI] = dataI;
                end
                if (ap_start) begin
                    err_d   = 1'b0;
                    col_d   = '0;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_end) begin
                    cur_k_d = '0;
                    state_d = S_DONE;
                end else if (fetch_ovf) begin
                    err_d   = 1'b1;
                    cur_k_d = '0;
                    state_d = S_DONE;
                end else begin
                    cur_k_d = fetch_k;
                    len_d   = fetch_len;
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                rd_en  = 1'b1;
                rd_col = COL_W'(col_q + cnt_q);
                if (cnt_q == len_q - 1'b1) begin
                    col_d   = col_q + len_q;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d   = '0;
                state_d = S_WB;
            end
            S_WB: begin
                res_wr   = 1'b1;
                res_sel  = cnt_q[3:0];
                res_addr = RES_AW'(idx_q) * RES_AW'(TILE_N) + RES_AW'(cnt_q);
                if (cnt_q == CW'(TILE_N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CLEAR: begin
                arr_clr = 1'b1;
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NUM_INST; i++) begin
                inst_q[i] <= '0;
            end
            col_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cur_k_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cur_k_q <= cur_k_d;
            err_q   <= err_d;
        end
    end

    assign ap_done         = (state_q == S_DONE);
    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign currInstruction = cur_k_q;
    assign err             = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - self-checking bench for inst_sequencer
module tb_inst_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] addrI;
    logic [4:0] dataI;
    logic       enI;
    logic       ap_start;
    logic       ap_done;
    logic [4:0] currInstruction;
    logic       busy;
    logic       rd_en;
    logic [7:0] rd_col;
    logic       arr_clr;
    logic       res_wr;
    logic [6:0] res_addr;
    logic [3:0] res_sel;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .addrI           (addrI),
        .dataI           (dataI),
        .enI             (enI),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .currInstruction (currInstruction),
        .busy            (busy),
        .rd_en           (rd_en),
        .rd_col          (rd_col),
        .arr_clr         (arr_clr),
        .res_wr          (res_wr),
        .res_addr        (res_addr),
        .res_sel         (res_sel),
        .err             (err)
    );

    typedef struct {
        logic [0:7][4:0] prog;
        int              n_rd;
        int              n_wr;
        int              n_clr;
        int              last_col;
        int              err;
        int              done_n;   // negedge index after start edge where ap_done is first seen
    } vec_t;

    vec_t vecs [7];
    vec_t v_empty;

    function automatic logic [0:7][4:0] pk(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
        logic [0:7][4:0] p;
        p[0] = 5'(a0); p[1] = 5'(a1); p[2] = 5'(a2); p[3] = 5'(a3);
        p[4] = 5'(a4); p[5] = 5'(a5); p[6] = 5'(a6); p[7] = 5'(a7);
        return p;
    endfunction

    function automatic vec_t mk(input logic [0:7][4:0] p, input int rd, input int wr, input int clr,
                                input int lc, input int e, input int dn);
        vec_t v;
        v.prog = p; v.n_rd = rd; v.n_wr = wr; v.n_clr = clr;
        v.last_col = lc; v.err = e; v.done_n = dn;
        return v;
    endfunction

    task automatic chk(input string tag, input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d, expected %0d", tag, name, act, exp);
        end
    endtask

    task automatic load_prog(input logic [0:7][4:0] p);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addrI = 3'(i);
            dataI = p[i];
            enI   = 1'b1;
        end
        @(negedge clk);
        enI = 1'b0;
    endtask

    task automatic run(input vec_t v, input bit load, input bit abuse, input string tag);
        int n, nrd, nwr, nclr, lastc, expc, expa;
        bit done;
        n = 0; nrd = 0; nwr = 0; nclr = 0; lastc = -1; expc = 0; expa = 0; done = 0;
        if (load) load_prog(v.prog);
        @(negedge clk);
        ap_start = 1'b1;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) ap_start = 1'b0;
            chk(tag, "strobe_overlap", int'(rd_en) + int'(res_wr) + int'(arr_clr) > 1, 0);
            if (rd_en) begin
                chk(tag, "rd_col", rd_col, expc);
                chk(tag, "currInstruction", currInstruction, v.prog[nclr[2:0]]);
                expc++;
                nrd++;
                lastc = rd_col;
            end else begin
                chk(tag, "rd_col_idle", rd_col, 0);
            end
            if (res_wr) begin
                chk(tag, "res_addr", res_addr, expa);
                chk(tag, "res_sel", res_sel, expa % 16);
                expa++;
                nwr++;
            end else begin
                chk(tag, "res_addr_idle", res_addr, 0);
                chk(tag, "res_sel_idle", res_sel, 0);
            end
            if (arr_clr) nclr++;
            if (ap_done) begin
                done = 1;
                chk(tag, "done_cycle", n, v.done_n);
                chk(tag, "busy_done", busy, 0);
                chk(tag, "curr_done", currInstruction, 0);
                chk(tag, "err", err, v.err);
            end else begin
                chk(tag, "busy_run", busy, 1);
            end
            // Protocol abuse mid-STREAM: both requests must be ignored.
            if (abuse && n == 5) begin
                ap_start = 1'b1; enI = 1'b1; addrI = 3'd0; dataI = 5'd9;
            end
            if (abuse && n == 6) begin
                ap_start = 1'b0; enI = 1'b0;
            end
        end
        chk(tag, "timeout", done, 1);
        chk(tag, "n_rd", nrd, v.n_rd);
        chk(tag, "n_wr", nwr, v.n_wr);
        chk(tag, "n_clr", nclr, v.n_clr);
        chk(tag, "last_col", lastc, v.last_col);
    endtask

    initial begin
        int wait_n;
        rst = 1'b1; addrI = '0; dataI = '0; enI = 1'b0; ap_start = 1'b0;

        vecs[0] = mk(pk(4, 0, 0, 0, 0, 0, 0, 0), 10, 16, 1, 9, 0, 31);
        vecs[1] = mk(pk(4, 2, 3, 0, 0, 0, 0, 0), 29, 48, 3, 28, 0, 88);
        vecs[2] = mk(pk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, -1, 0, 2);
        vecs[3] = mk(pk(31, 31, 31, 31, 31, 31, 31, 31), 227, 96, 6, 226, 1, 343);
        vecs[4] = mk(pk(1, 1, 1, 1, 1, 1, 1, 1), 63, 128, 8, 62, 0, 217);
        vecs[5] = mk(pk(31, 31, 31, 31, 31, 31, 22, 0), 256, 112, 7, 255, 0, 391);
        vecs[6] = mk(pk(31, 31, 31, 31, 31, 31, 23, 0), 227, 96, 6, 226, 1, 343);
        v_empty = vecs[2];

        repeat (2) @(negedge clk);
        chk("reset", "ap_done", ap_done, 0);
        chk("reset", "busy", busy, 0);
        chk("reset", "rd_en", rd_en, 0);
        chk("reset", "res_wr", res_wr, 0);
        chk("reset", "arr_clr", arr_clr, 0);
        chk("reset", "err", err, 0);
        chk("reset", "currInstruction", currInstruction, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i], 1'b1, 1'b0, $sformatf("vec%0d", i));
        end

        // ap_start/enI pulsed mid-STREAM, then rerun without reloading.
        run(vecs[0], 1'b1, 1'b1, "abuse");
        run(vecs[0], 1'b0, 1'b0, "abuse_rerun");

        // Reset in the middle of write-back.
        load_prog(vecs[0].prog);
        @(negedge clk);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        wait_n = 0;
        while (!res_wr && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        chk("rst_wb", "reached_wb", res_wr, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wb", "busy", busy, 0);
        chk("rst_wb", "res_wr", res_wr, 0);
        chk("rst_wb", "res_addr", res_addr, 0);
        chk("rst_wb", "res_sel", res_sel, 0);
        chk("rst_wb", "rd_en", rd_en, 0);
        chk("rst_wb", "arr_clr", arr_clr, 0);
        chk("rst_wb", "ap_done", ap_done, 0);
        chk("rst_wb", "currInstruction", currInstruction, 0);
        @(negedge clk);
        chk("rst_wb", "res_wr_after", res_wr, 0);
        // Reset cleared the instruction memory, so an unloaded start is an empty program.
        run(v_empty, 1'b0, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
